// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC sequencing, 1-cycle imem read, 2-entry tagged queue to decode
// Optional HLT detection is compiled in with `define FETCH_HALT_EN.
module fetch_unit #(
    parameter int unsigned PC_W        = 5,
    parameter int unsigned INSTR_W     = 8,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    output logic               pc_write,
    output logic [PC_W-1:0]    next_pc,
    output logic               imem_re,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         count_q, count_d;
    logic               pending_q, pending_d;
    logic [PC_W-1:0]    pending_pc_q, pending_pc_d;
    logic [INSTR_W-1:0] q_instr_q [2];
    logic [INSTR_W-1:0] q_instr_d [2];
    logic [PC_W-1:0]    q_pc_q [2];
    logic [PC_W-1:0]    q_pc_d [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       halt_flag;
    logic       hlt_push;
    logic [2:0] occupancy;

    assign out_valid = (count_q != 2'd0);
    assign out_instr = q_instr_q[0];
    assign out_pc    = q_pc_q[0];

    assign pop       = out_valid & out_ready;
    assign push      = pending_q & ~redirect;
    assign halt_flag = (state_q == ST_HALTED);

    // Counting the in-flight read against capacity guarantees every response has a free slot.
    assign occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
    assign issue     = ~reset & fetch_en & ~redirect & ~halt_flag & (occupancy < 3'd2);

    assign imem_re   = issue;
    assign imem_addr = pc_in;
    assign pc_write  = ~reset & (redirect | issue);
    assign next_pc   = redirect ? redirect_pc : pc_in + PC_W'(1);

`ifdef FETCH_HALT_EN
    assign hlt_push = push & (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
    assign halted   = halt_flag;
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign hlt_push = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (hlt_push) state_d = ST_HALTED;
            ST_HALTED: if (redirect) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        q_instr_d    = q_instr_q;
        q_pc_d       = q_pc_q;
        pending_d    = issue;
        pending_pc_d = issue ? pc_in : pending_pc_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    q_instr_d[0] = q_instr_q[1];
                    q_pc_d[0]    = q_pc_q[1];
                    count_d      = count_q - 2'd1;
                end
                2'b10: begin
                    q_instr_d[count_q[0]] = imem_rdata;
                    q_pc_d[count_q[0]]    = pending_pc_q;
                    count_d               = count_q + 2'd1;
                end
                2'b11: begin
                    // Head leaves as the new entry arrives; a full queue shifts, a single entry is replaced.
                    if (count_q == 2'd2) begin
                        q_instr_d[0] = q_instr_q[1];
                        q_pc_d[0]    = q_pc_q[1];
                        q_instr_d[1] = imem_rdata;
                        q_pc_d[1]    = pending_pc_q;
                    end else begin
                        q_instr_d[0] = imem_rdata;
                        q_pc_d[0]    = pending_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            count_q      <= 2'd0;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            q_instr_q[0] <= '0;
            q_instr_q[1] <= '0;
            q_pc_q[0]    <= '0;
            q_pc_q[1]    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            q_instr_q    <= q_instr_d;
            q_pc_q       <= q_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit with PC and imem models
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pc_in;
    logic       pc_write;
    logic [4:0] next_pc;
    logic       imem_re;
    logic [4:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       fetch_en;
    logic       redirect;
    logic [4:0] redirect_pc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_instr;
    logic [4:0] out_pc;
    logic       halted;

    logic [7:0] mem [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_write   (pc_write),
        .next_pc    (next_pc),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .fetch_en   (fetch_en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .halted     (halted)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) pc_in <= 5'd0;
        else if (pc_write) pc_in <= next_pc;
    end

    always @(posedge clk) begin
        if (imem_re) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic       rst, fe, rdy, rd;
        logic [4:0] rpc;
        logic       ev;
        logic [4:0] epc;
        logic [7:0] eins;
        logic       epw;
        logic [4:0] enpc;
        logic       ere;
        logic [4:0] epcin;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fe, input logic rdy, input logic rd,
                                input logic [4:0] rpc, input logic ev, input logic [4:0] epc,
                                input logic [7:0] eins, input logic epw, input logic [4:0] enpc,
                                input logic ere, input logic [4:0] epcin);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eins = eins; v.epw = epw; v.enpc = enpc;
        v.ere = ere; v.epcin = epcin;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
        reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 5'd0;

        // stream from reset
        vecs.push_back(mk(1,1,1,0,0,  0,0,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,1,1,0));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,2,1,1));
        vecs.push_back(mk(0,1,1,0,0,  1,0,8'h10,  1,3,1,2));
        vecs.push_back(mk(0,1,1,0,0,  1,1,8'h11,  1,4,1,3));
        vecs.push_back(mk(0,1,1,0,0,  1,2,8'h12,  1,5,1,4));
        vecs.push_back(mk(0,1,1,0,0,  1,3,8'h13,  1,6,1,5));
        // decode stalled for five cycles
        vecs.push_back(mk(1,1,0,0,0,  0,0,0,      0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,  0,0,0,      1,1,1,0));
        vecs.push_back(mk(0,1,0,0,0,  0,0,0,      1,2,1,1));
        vecs.push_back(mk(0,1,0,0,0,  1,0,8'h10,  0,0,0,2));
        vecs.push_back(mk(0,1,0,0,0,  1,0,8'h10,  0,0,0,2));
        vecs.push_back(mk(0,1,0,0,0,  1,0,8'h10,  0,0,0,2));
        vecs.push_back(mk(0,1,1,0,0,  1,0,8'h10,  1,3,1,2));
        vecs.push_back(mk(0,1,1,0,0,  1,1,8'h11,  1,4,1,3));
        vecs.push_back(mk(0,1,1,0,0,  1,2,8'h12,  1,5,1,4));
        // redirect with an entry queued and a response in flight
        vecs.push_back(mk(1,1,0,0,0,  0,0,0,      0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,  0,0,0,      1,1,1,0));
        vecs.push_back(mk(0,1,0,0,0,  0,0,0,      1,2,1,1));
        vecs.push_back(mk(0,1,0,1,20, 1,0,8'h10,  1,20,0,2));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,21,1,20));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,22,1,21));
        vecs.push_back(mk(0,1,1,0,0,  1,20,8'h24, 1,23,1,22));
        vecs.push_back(mk(0,1,1,0,0,  1,21,8'h25, 1,24,1,23));
        // PC wrap 30,31,0,1
        vecs.push_back(mk(1,1,1,0,0,  0,0,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,1,30, 0,0,0,      1,30,0,0));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,31,1,30));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,0,1,31));
        vecs.push_back(mk(0,1,1,0,0,  1,30,8'h2E, 1,1,1,0));
        vecs.push_back(mk(0,1,1,0,0,  1,31,8'h2F, 1,2,1,1));
        vecs.push_back(mk(0,1,1,0,0,  1,0,8'h10,  1,3,1,2));
        vecs.push_back(mk(0,1,1,0,0,  1,1,8'h11,  1,4,1,3));
        // fetch disabled: in-flight response still lands, queue drains
        vecs.push_back(mk(0,0,1,0,0,  1,2,8'h12,  0,0,0,4));
        vecs.push_back(mk(0,0,1,0,0,  1,3,8'h13,  0,0,0,4));
        vecs.push_back(mk(0,0,1,0,0,  0,0,0,      0,0,0,4));
        vecs.push_back(mk(0,1,1,0,0,  0,0,0,      1,5,1,4));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; fetch_en = vecs[i].fe; out_ready = vecs[i].rdy;
            redirect = vecs[i].rd; redirect_pc = vecs[i].rpc;
            @(negedge clk);
            chk("out_valid", i, int'(out_valid), int'(vecs[i].ev));
            chk("pc_write",  i, int'(pc_write),  int'(vecs[i].epw));
            chk("imem_re",   i, int'(imem_re),   int'(vecs[i].ere));
            chk("pc_in",     i, int'(pc_in),     int'(vecs[i].epcin));
            chk("halted",    i, int'(halted),    0);
            if (vecs[i].ev) begin
                chk("out_pc",    i, int'(out_pc),    int'(vecs[i].epc));
                chk("out_instr", i, int'(out_instr), int'(vecs[i].eins));
            end
            if (vecs[i].epw) chk("next_pc", i, int'(next_pc), int'(vecs[i].enpc));
            if (vecs[i].ere) chk("imem_addr", i, int'(imem_addr), int'(vecs[i].epcin));
            next_cycle();
        end

        // asynchronous reset pulse between clock edges
        fetch_en = 1'b1; out_ready = 1'b1; redirect = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("pre_rst_valid", 100, int'(out_valid), 1);
        chk("pre_rst_pc",    100, int'(out_pc),    4);
        #1 reset = 1'b1;
        #1;
        chk("rst_valid",    101, int'(out_valid), 0);
        chk("rst_pc_write", 101, int'(pc_write),  0);
        chk("rst_imem_re",  101, int'(imem_re),   0);
        chk("rst_out_pc",   101, int'(out_pc),    0);
        #1 reset = 1'b0;
        #1;
        chk("rel_pc_write", 102, int'(pc_write),  1);
        chk("rel_next_pc",  102, int'(next_pc),   1);
        chk("rel_addr",     102, int'(imem_addr), 0);
        @(posedge clk);
        next_cycle();
        chk("rel_valid0", 103, int'(out_valid), 1);
        chk("rel_pc0",    103, int'(out_pc),    0);
        chk("rel_instr0", 103, int'(out_instr), 8'h10);
        next_cycle();
        chk("rel_pc1",    104, int'(out_pc),    1);

`ifdef FETCH_HALT_EN
        reset = 1'b1;
        mem[3] = 8'hF0;
        next_cycle();
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("h_re0",   200, int'(imem_re),   1);
        chk("h_addr0", 200, int'(imem_addr), 0);
        repeat (4) next_cycle();
        @(negedge clk);
        chk("h_re4",     204, int'(imem_re),   1);
        chk("h_addr4",   204, int'(imem_addr), 4);
        chk("h_pc2",     204, int'(out_pc),    2);
        chk("h_halted4", 204, int'(halted),    0);
        next_cycle();
        @(negedge clk);
        chk("h_halted5", 205, int'(halted),    1);
        chk("h_pc3",     205, int'(out_pc),    3);
        chk("h_instr3",  205, int'(out_instr), 8'hF0);
        chk("h_re5",     205, int'(imem_re),   0);
        chk("h_pw5",     205, int'(pc_write),  0);
        next_cycle();
        @(negedge clk);
        chk("h_pc4",    206, int'(out_pc),    4);
        chk("h_instr4", 206, int'(out_instr), 8'h14);
        chk("h_re6",    206, int'(imem_re),   0);
        next_cycle();
        redirect = 1'b1; redirect_pc = 5'd7;
        @(negedge clk);
        chk("h_valid7",   207, int'(out_valid), 0);
        chk("h_halted7",  207, int'(halted),    1);
        chk("h_rd_pw",    207, int'(pc_write),  1);
        chk("h_rd_npc",   207, int'(next_pc),   7);
        chk("h_rd_re",    207, int'(imem_re),   0);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("h_halted8", 208, int'(halted),    0);
        chk("h_re8",     208, int'(imem_re),   1);
        chk("h_addr8",   208, int'(imem_addr), 7);
        repeat (2) next_cycle();
        @(negedge clk);
        chk("h_valid10", 210, int'(out_valid), 1);
        chk("h_pc7",     210, int'(out_pc),    7);
        chk("h_instr7",  210, int'(out_instr), 8'h17);
        mem[3] = 8'h13;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
